// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: bundles the instruction-memory, EX redirect, ID handshake and performance
// counter signals of the fetch queue.
//   master : fetch-queue side (drives imem_*, id_valid/pc/instr, perf_*)
//   slave  : environment side (drives imem_resp/rdata, redirect_*, id_ready)
interface if_fetch_queue_if;
   logic [31:0] imem_address;
   logic        imem_read;
   logic        imem_resp;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_ready;
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;

   modport master (
      output imem_address, imem_read,
      input  imem_resp, imem_rdata,
      input  redirect_valid, redirect_pc,
      output id_valid, id_pc, id_instr,
      input  id_ready,
      output perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt
   );

   modport slave (
      input  imem_address, imem_read,
      output imem_resp, imem_rdata,
      output redirect_valid, redirect_pc,
      input  id_valid, id_pc, id_instr,
      output id_ready,
      input  perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt
   );
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage with a DEPTH-entry {pc, instr} buffer feeding ID.
// Owns the fetch PC, keeps at most one request outstanding to instruction memory, and flushes
// the buffer / squashes the in-flight fetch on an EX redirect.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-low reset
//   bus  - if_fetch_queue_if.master: imem request/response, redirect, ID valid/ready, perf counters
// Optional feature: define IF_PERF_CNT_EN to instantiate the three 32-bit performance counters;
// otherwise perf_* outputs are tied to zero.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h4000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input logic              clk,
   input logic              rst,
   if_fetch_queue_if.master bus
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {StFetch, StWait, StDrop} state_e;

   state_e          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     imem_addr_q, imem_addr_d;
   logic            imem_read_q, imem_read_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [31:0]     pc_mem_q    [DEPTH];
   logic [31:0]     instr_mem_q [DEPTH];

   logic            head_valid;
   logic            enq;
   logic            deq;
   logic [31:0]     redirect_tgt;
   logic            unused_rpc_lsbs;

   assign head_valid      = (count_q != '0);
   assign redirect_tgt    = {bus.redirect_pc[31:2], 2'b00};
   assign unused_rpc_lsbs = ^bus.redirect_pc[1:0];

   // Redirect wins: a same-cycle response is discarded and a same-cycle dequeue is dropped.
   assign enq = (state_q == StFetch) && bus.imem_resp && !bus.redirect_valid;
   assign deq = head_valid && bus.id_ready && !bus.redirect_valid;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;

      if (bus.redirect_valid) begin
         fetch_pc_d = redirect_tgt;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         unique case (state_q)
            // Without a response the old request is still in flight; wait it out in DROP.
            StFetch: state_d = bus.imem_resp ? StFetch : StDrop;
            StWait:  state_d = StFetch;
            StDrop:  state_d = StDrop;
            default: state_d = StFetch;
         endcase
      end else begin
         if (enq) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CntW'(enq) - CntW'(deq);
         unique case (state_q)
            StFetch: if (count_d == CntW'(DEPTH)) state_d = StWait;
            StWait:  if (count_d <  CntW'(DEPTH)) state_d = StFetch;
            StDrop:  if (bus.imem_resp)           state_d = StFetch;
            default: state_d = StFetch;
         endcase
      end

      // Request outputs are registered off the next state; DROP keeps the squashed address
      // stable until its response arrives.
      imem_read_d = (state_d != StWait);
      imem_addr_d = (state_d == StDrop) ? imem_addr_q : fetch_pc_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StFetch;
         fetch_pc_q  <= RESET_PC;
         imem_addr_q <= RESET_PC;
         imem_read_q <= 1'b1;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         imem_addr_q <= imem_addr_d;
         imem_read_q <= imem_read_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
      end
   end

   // Storage needs no reset: reads are masked by count.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
         instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
      end
   end

   assign bus.imem_address = imem_addr_q;
   assign bus.imem_read    = imem_read_q;
   assign bus.id_valid     = head_valid;
   assign bus.id_pc        = head_valid ? pc_mem_q[rd_ptr_q]    : 32'd0;
   assign bus.id_instr     = head_valid ? instr_mem_q[rd_ptr_q] : 32'd0;

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_q;
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_fetch_q <= '0;
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (enq)                           perf_fetch_q <= perf_fetch_q + 32'd1;
         if (head_valid && !bus.id_ready)   perf_stall_q <= perf_stall_q + 32'd1;
         if (bus.redirect_valid)            perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign bus.perf_fetch_cnt = perf_fetch_q;
   assign bus.perf_stall_cnt = perf_stall_q;
   assign bus.perf_flush_cnt = perf_flush_q;
`else
   assign bus.perf_fetch_cnt = 32'd0;
   assign bus.perf_stall_cnt = 32'd0;
   assign bus.perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed, table-driven bench for if_fetch_queue (DEPTH=2). Each table row
// is one clock cycle: inputs applied at the falling edge and the outputs expected in that cycle.
// Hand-written sequences afterwards cover the performance counters and mid-stream reset.
module tb_if_fetch_queue;

   logic clk;
   logic rst;

   if_fetch_queue_if bus ();

   if_fetch_queue #(
      .RESET_PC (32'h4000_0000),
      .DEPTH    (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        resp;
      logic [31:0] rdata;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic        exp_read;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vecs[$];
   int   n_checks;
   int   n_fail;

   function automatic vec_t mk(logic r, logic rs, logic [31:0] rd, logic rv, logic [31:0] rp,
                               logic ry, logic er, logic [31:0] ea, logic ev, logic [31:0] ep,
                               logic [31:0] ei);
      vec_t v;
      v.rst = r; v.resp = rs; v.rdata = rd; v.redir = rv; v.rpc = rp; v.ready = ry;
      v.exp_read = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_instr = ei;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rs, input logic [31:0] rd, input logic rv,
                        input logic [31:0] rp, input logic ry);
      rst                = r;
      bus.imem_resp      = rs;
      bus.imem_rdata     = rd;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rp;
      bus.id_ready       = ry;
   endtask

   task automatic check_perf(input string tag, input logic [31:0] ef, input logic [31:0] es,
                             input logic [31:0] efl);
      check({tag, " perf_fetch"}, bus.perf_fetch_cnt, ef);
      check({tag, " perf_stall"}, bus.perf_stall_cnt, es);
      check({tag, " perf_flush"}, bus.perf_flush_cnt, efl);
   endtask

   logic [31:0] exp_pf, exp_ps, exp_pfl;

   initial begin
      n_checks = 0;
      n_fail   = 0;
`ifdef IF_PERF_CNT_EN
      exp_pf = 32'd2; exp_ps = 32'd1; exp_pfl = 32'd1;
`else
      exp_pf = 32'd0; exp_ps = 32'd0; exp_pfl = 32'd0;
`endif

      //           rst rsp rdata          rv rpc            rdy| rd addr           v  pc             instr
      // Streaming with ID always ready
      vecs.push_back(mk(1, 1, 32'hA000_0000, 0, 32'h0,        1, 1, 32'h4000_0000, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 32'hA000_0004, 0, 32'h0,        1, 1, 32'h4000_0004, 1, 32'h4000_0000, 32'hA000_0000));
      vecs.push_back(mk(1, 1, 32'hA000_0008, 0, 32'h0,        1, 1, 32'h4000_0008, 1, 32'h4000_0004, 32'hA000_0004));
      // ID stalls: buffer fills, request drops (WAIT), one ready pulse reopens fetch
      vecs.push_back(mk(1, 1, 32'hA000_000C, 0, 32'h0,        0, 1, 32'h4000_000C, 1, 32'h4000_0008, 32'hA000_0008));
      vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,        0, 0, 32'h4000_0010, 1, 32'h4000_0008, 32'hA000_0008));
      vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,        1, 0, 32'h4000_0010, 1, 32'h4000_0008, 32'hA000_0008));
      // Redirect with a request outstanding: address held, response discarded
      vecs.push_back(mk(1, 0, 32'h0,         1, 32'h4000_0103, 0, 1, 32'h4000_0010, 1, 32'h4000_000C, 32'hA000_000C));
      vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,        0, 1, 32'h4000_0010, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,        0, 1, 32'h4000_0010, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 32'hDEAD_BEEF, 0, 32'h0,        1, 1, 32'h4000_0010, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 32'hA000_0100, 0, 32'h0,        1, 1, 32'h4000_0100, 0, 32'h0,        32'h0));
      // Redirect coinciding with response and dequeue
      vecs.push_back(mk(1, 1, 32'hA000_0104, 1, 32'h4000_0180, 1, 1, 32'h4000_0104, 1, 32'h4000_0100, 32'hA000_0100));
      // Two redirects while a squashed request is pending: only the newest target is fetched
      vecs.push_back(mk(1, 0, 32'h0,         1, 32'h4000_0200, 1, 1, 32'h4000_0180, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 0, 32'h0,         1, 32'h4000_0300, 1, 1, 32'h4000_0180, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 32'hBAD0_0180, 0, 32'h0,        1, 1, 32'h4000_0180, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 32'hA000_0300, 0, 32'h0,        0, 1, 32'h4000_0300, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 32'hA000_0304, 0, 32'h0,        0, 1, 32'h4000_0304, 1, 32'h4000_0300, 32'hA000_0300));
      // Redirect from WAIT: immediate request to the target
      vecs.push_back(mk(1, 0, 32'h0,         1, 32'h4000_0401, 0, 0, 32'h4000_0308, 1, 32'h4000_0300, 32'hA000_0300));
      vecs.push_back(mk(1, 1, 32'hA000_0400, 0, 32'h0,        1, 1, 32'h4000_0400, 0, 32'h0,        32'h0));
      // Reset mid-request
      vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        0, 1, 32'h4000_0404, 1, 32'h4000_0400, 32'hA000_0400));
      // PC wrap at the top of the address space
      vecs.push_back(mk(1, 0, 32'h0,         1, 32'hFFFF_FFFE, 0, 1, 32'h4000_0000, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 32'hBAD0_0000, 0, 32'h0,        0, 1, 32'h4000_0000, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 32'hA000_FFFC, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0));
      vecs.push_back(mk(1, 1, 32'hA000_0000, 0, 32'h0,        1, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'hA000_FFFC));
      vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,        1, 1, 32'h0000_0004, 1, 32'h0000_0000, 32'hA000_0000));
      vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,        1, 1, 32'h0000_0004, 0, 32'h0,        32'h0));

      drive(0, 0, 32'h0, 0, 32'h0, 0);
      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].resp, vecs[i].rdata, vecs[i].redir, vecs[i].rpc,
               vecs[i].ready);
         check($sformatf("v%0d imem_read", i),    32'(bus.imem_read), 32'(vecs[i].exp_read));
         check($sformatf("v%0d imem_address", i), bus.imem_address,   vecs[i].exp_addr);
         check($sformatf("v%0d id_valid", i),     32'(bus.id_valid),  32'(vecs[i].exp_valid));
         check($sformatf("v%0d id_pc", i),        bus.id_pc,          vecs[i].exp_pc);
         check($sformatf("v%0d id_instr", i),     bus.id_instr,       vecs[i].exp_instr);
      end

      // Performance counter sequence, starting from a fresh reset
      @(negedge clk);
      drive(0, 0, 32'h0, 0, 32'h0, 0);
      @(negedge clk);
      check_perf("rst0", 32'd0, 32'd0, 32'd0);
      check("rst0 imem_address", bus.imem_address, 32'h4000_0000);
      drive(1, 1, 32'hA000_0000, 0, 32'h0, 0);       // enqueue, head empty: no stall
      @(negedge clk);
      check("p1 id_pc", bus.id_pc, 32'h4000_0000);
      drive(1, 1, 32'hA000_0004, 0, 32'h0, 0);       // enqueue -> full, stall 1
      @(negedge clk);
      check("p2 imem_read", 32'(bus.imem_read), 32'd0);
      drive(1, 0, 32'h0, 0, 32'h0, 1);               // dequeue -> back to FETCH
      @(negedge clk);
      check("p3 imem_read", 32'(bus.imem_read), 32'd1);
      check("p3 imem_address", bus.imem_address, 32'h4000_0008);
      drive(1, 1, 32'hA000_0008, 1, 32'h4000_0500, 1); // redirect + resp + ready together
      @(negedge clk);
      check("p4 id_valid", 32'(bus.id_valid), 32'd0);
      check("p4 imem_address", bus.imem_address, 32'h4000_0500);
      check_perf("p4", exp_pf, exp_ps, exp_pfl);
      drive(1, 1, 32'hA000_0500, 0, 32'h0, 0);
      @(negedge clk);
      check("p5 id_valid", 32'(bus.id_valid), 32'd1);
      drive(0, 1, 32'hA000_0504, 0, 32'h0, 0);       // reset while a request is active
      @(negedge clk);
      drive(1, 0, 32'h0, 0, 32'h0, 0);
      check("p6 id_valid", 32'(bus.id_valid), 32'd0);
      check("p6 imem_read", 32'(bus.imem_read), 32'd1);
      check("p6 imem_address", bus.imem_address, 32'h4000_0000);
      check_perf("p6", 32'd0, 32'd0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction-fetch stage and fetch buffer that sits directly upstream of the ID-stage decoder. It owns the fetch PC and runs a single-outstanding-request handshake with the instruction memory/cache. Returned instructions go into a DEPTH-entry FIFO of {pc, instruction}, which feeds ID through a valid/ready handshake. Redirect requests from EX (taken branch, jal, jalr) flush the buffer and squash any in-flight fetch.

## Interface
Parameters:
- RESET_PC, 32'h4000_0000, fetch PC loaded on reset
- DEPTH, 2, buffer entries; power of two, 2..8

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; **one clock; reset is synchronous and active-low** (rst==0 at a clk edge resets)
- imem_address  out  32  fetch address; equals fetch_pc, 4-byte aligned
- imem_read  out  1  fetch request; held with stable address until imem_resp
- imem_resp  in  1  one-cycle pulse; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- redirect_valid  in  1  EX redirect, single-cycle pulse
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0
- id_valid  out  1  buffer head valid
- id_pc  out  32  head PC (drives decoder pc_i)
- id_instr  out  32  head instruction (drives decoder instr_i)
- id_ready  in  1  ID accepts head this cycle
- perf_fetch_cnt  out  32  instructions enqueued
- perf_stall_cnt  out  32  cycles with id_valid & ~id_ready
- perf_flush_cnt  out  32  redirects taken

## Operation
- Reset values: fetch_pc=RESET_PC, state=FETCH, count=0, rd/wr pointers=0, id_valid=0, id_pc=0, id_instr=0, all perf counters=0. imem_read=1 in the first cycle after reset.
- The FSM has three states.
  - FETCH: imem_read=1, address=fetch_pc.
    - On imem_resp: enqueue {fetch_pc, imem_rdata} and set fetch_pc+=4.
    - Stay in FETCH if the post-edge count < DEPTH; otherwise go to WAIT.
  - WAIT: imem_read=0. Return to FETCH once count < DEPTH after any dequeue.
  - DROP: imem_read=1 with the address held at the squashed fetch address. On imem_resp, discard the data and go to FETCH at the saved redirect PC.
- Enqueue happens only in FETCH on imem_resp. A request is only issued while count < DEPTH, so an enqueue never finds the buffer full.
- Dequeue occurs when id_valid & id_ready; rd pointer advances.
- Simultaneous enqueue and dequeue leaves count unchanged; both pointers advance. Pointers wrap modulo DEPTH.
- id_valid = (count != 0). id_pc and id_instr show the head entry, combinationally from buffer storage. When empty they read 0.
- Redirect has priority over enqueue and dequeue in the same cycle:
  - count is cleared to 0 and pointers reset to 0.
  - Any same-cycle dequeue is dropped; ID must ignore it.
  - Any same-cycle imem_resp is discarded.
  - fetch_pc is set to {redirect_pc[31:2], 2'b00}.
- Redirect next-state depends on the memory handshake:
  - If in FETCH without imem_resp this cycle: go to DROP; the redirect target is saved.
  - If in FETCH with imem_resp this cycle: go to FETCH.
  - If in WAIT: go to FETCH.
  - If in DROP: stay in DROP; the target is overwritten with the newest redirect_pc.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- Reset asserted mid-request drops all state. The memory side must tolerate the abandoned request.

## Timing
- Fetch-to-ID latency: an imem_resp at cycle N makes id_valid=1 with that entry at cycle N+1. There is no bypass.
- Throughput: with a 1-cycle-hit memory, one instruction per cycle sustained when ID is always ready.
- Redirect at cycle N:
  - id_valid=0 at N+1.
  - From FETCH-with-resp or WAIT: the first request to the target is issued at N+1.
  - From FETCH-without-resp or DROP: it is issued in the cycle after the pending imem_resp.
- imem_address and imem_read are registered; there is no combinational path from imem_resp to imem_read or imem_address.
- id_ready reaches only the counters, pointers and next-state logic; it has no combinational path to imem_*.

## Configuration
- IF_PERF_CNT_EN defined:
  - The three 32-bit wrapping counters increment as described; reset clears them.
  - perf_fetch_cnt counts non-discarded enqueues.
  - perf_flush_cnt counts cycles with redirect_valid=1.
- IF_PERF_CNT_EN undefined: counters are not instantiated and the perf_* outputs are tied to 0.

## Test plan
- Reset, then 1-cycle memory and id_ready=1 → id_pc = 4000_0000, 4000_0004, 4000_0008 on consecutive cycles starting at the cycle after the first imem_resp.
- id_ready=0 with DEPTH=2 → exactly 2 enqueues, then imem_read=0 (WAIT). perf_stall_cnt increments every cycle that id_valid=1. One id_ready pulse → one new request to 4000_0008.
- Redirect to 32'h4000_0103 while a request to 4000_0010 is outstanding, with resp 3 cycles later:
  - imem_address stays at 4000_0010 until resp, and that data is discarded.
  - The next request goes to 4000_0100.
  - id_valid=0 throughout.
- Redirect in the same cycle as imem_resp and id_ready → no enqueue, count=0, next cycle imem_address = target and id_valid=0. perf_flush_cnt=1 when the macro is enabled.
- Two redirects (4000_0200 then 4000_0300) while in DROP → only 4000_0300 is fetched after the pending response.
- rst=0 while imem_read is high mid-stream → next cycle count=0, id_valid=0, imem_address = RESET_PC, perf counters = 0.
